// File: rtl/unique0_tlb_pkg.sv
// Shared types and constants for the unified Sv32 TLB: entry layouts, store geometry
// and the flush FSM state encoding.
package tlb_pkg;

    localparam int FLAG_V        = 0;
    localparam int FLAG_G        = 5;
    localparam int SETS          = 512;
    localparam int WAYS          = 4;
    localparam int SUPER_ENTRIES = 1024;

    typedef struct packed {
        logic [10:0] tag;
        logic [8:0]  asid;
        logic [16:0] ppn;
        logic [7:0]  flags;
        logic [2:0]  pad;
    } pageEntry_t;

    typedef struct packed {
        logic [8:0] asid;
        logic [6:0] ppn;
        logic [7:0] flags;
    } superEntry_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } flushState_t;

    // Isolates the lowest set bit so multi-way selections resolve to a single way.
    function automatic logic [3:0] firstOne(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/unique0_tlb_if.sv
// Lookup/refill bus between address generation, the page-table walker and the TLB.
interface unique0_tlb_if;

    logic        busy;
    logic        read_req;
    logic [8:0]  read_asid;
    logic [19:0] read_addr;
    logic        read_hit;
    logic        read_super;
    logic [16:0] read_ppn;
    logic [7:0]  read_flags;
    logic        write_req;
    logic        write_super;
    logic [10:0] write_tag;
    logic [8:0]  write_asid;
    logic [16:0] write_ppn;
    logic [7:0]  write_flags;

    modport master (
        input  busy, read_hit, read_super, read_ppn, read_flags,
        output read_req, read_asid, read_addr,
        output write_req, write_super, write_tag, write_asid, write_ppn, write_flags
    );

    modport slave (
        output busy, read_hit, read_super, read_ppn, read_flags,
        input  read_req, read_asid, read_addr,
        input  write_req, write_super, write_tag, write_asid, write_ppn, write_flags
    );

endinterface

// File: rtl/unique0_tlb_plru.sv
// 3-bit tree pseudo-LRU for one 4-way set: picks the victim and computes the
// bits that result from touching the hit way.
module plru_tree (
    input  logic [2:0] lru_i,
    input  logic [3:0] hit_i,
    output logic [2:0] lru_o,
    output logic [3:0] victim_o
);

    always_comb begin
        victim_o = 4'b0000;
        if (!lru_i[2]) begin
            victim_o[lru_i[0] ? 1 : 0] = 1'b1;
        end else begin
            victim_o[lru_i[1] ? 3 : 2] = 1'b1;
        end
    end

    // Touching a way points the tree away from it; the other subtree's bit is kept.
    always_comb begin
        lru_o = lru_i;
        if (hit_i[0]) begin
            lru_o[2] = 1'b1;
            lru_o[0] = 1'b1;
        end else if (hit_i[1]) begin
            lru_o[2] = 1'b1;
            lru_o[0] = 1'b0;
        end else if (hit_i[2]) begin
            lru_o[2] = 1'b0;
            lru_o[1] = 1'b1;
        end else if (hit_i[3]) begin
            lru_o[2] = 1'b0;
            lru_o[1] = 1'b0;
        end
    end

endmodule

// File: rtl/unique0_tlb.sv
// Unified Sv32 TLB: direct-mapped superpage store plus 512x4 page store with tree PLRU.
// Optional refill trace printing is compiled in with the macro TLB_TRACE_EN.
module unique0_tlb
    import tlb_pkg::*;
#(
    parameter string PARENT = ""
) (
    input  logic          clk,
    input  logic          reset,
    unique0_tlb_if.slave  bus
);

    flushState_t             state_q;
    logic [9:0]              flushIdx_q;
    logic                    busy_q;

    logic                    lookupValid_q;
    logic                    lookupPulse_q;
    logic [8:0]              asid_q;
    logic [19:0]             addr_q;

    superEntry_t             superRd_q;
    pageEntry_t [WAYS-1:0]   setRd_q;
    logic [2:0]              lruRd_q;

    superEntry_t             superMem [SUPER_ENTRIES];
    pageEntry_t [WAYS-1:0]   pageMem  [SETS];
    logic [2:0]              lruMem   [SETS];

    logic                    lookupAccept;
    logic                    refillAccept;
    logic                    superHit;
    logic [WAYS-1:0]         wayHit;
    logic [WAYS-1:0]         victim;
    logic [WAYS-1:0]         waySel;
    logic [WAYS-1:0]         selOne;
    logic [2:0]              lru_d;
    pageEntry_t              selEntry;

    logic                    superWe;
    logic [9:0]              superWIdx;
    superEntry_t             superWData;
    logic                    pageWe;
    logic [WAYS-1:0]         pageWMask;
    logic [8:0]              pageWIdx;
    pageEntry_t              pageWData;
    logic                    lruWe;
    logic [8:0]              lruWIdx;
    logic [2:0]              lruWData;

    assign lookupAccept = bus.read_req  & ~busy_q & ~reset;
    assign refillAccept = bus.write_req & ~busy_q & ~reset & lookupValid_q;

    // Post-reset flush walks every superpage index; the page store shares the low half.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FLUSH;
            flushIdx_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                FLUSH: begin
                    flushIdx_q <= flushIdx_q + 10'd1;
                    if (flushIdx_q == 10'(SUPER_ENTRIES - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lookupValid_q <= 1'b0;
            lookupPulse_q <= 1'b0;
        end else begin
            lookupPulse_q <= lookupAccept;
            if (lookupAccept) begin
                lookupValid_q <= 1'b1;
                asid_q        <= bus.read_asid;
                addr_q        <= bus.read_addr;
            end
        end
    end

    always_comb begin
        superHit = lookupValid_q & superRd_q.flags[FLAG_V]
                 & (superRd_q.flags[FLAG_G] | (superRd_q.asid == asid_q));
        for (int w = 0; w < WAYS; w++) begin
            wayHit[w] = lookupValid_q & setRd_q[w].flags[FLAG_V]
                      & (setRd_q[w].flags[FLAG_G] | (setRd_q[w].asid == asid_q))
                      & (setRd_q[w].tag == addr_q[19:9]);
        end
    end

    plru_tree u_plru (
        .lru_i    (lruRd_q),
        .hit_i    (wayHit),
        .lru_o    (lru_d),
        .victim_o (victim)
    );

    assign waySel = (|wayHit) ? wayHit : victim;
    assign selOne = firstOne(waySel);

    always_comb begin
        selEntry = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (selOne[w]) begin
                selEntry = setRd_q[w];
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.read_hit   = ~busy_q & (superHit | (|wayHit));
    assign bus.read_super = ~busy_q & superHit;
    assign bus.read_ppn   = superHit ? {superRd_q.ppn, 10'b0} : selEntry.ppn;
    assign bus.read_flags = superHit ? superRd_q.flags : selEntry.flags;

    // Flush owns every write port while it runs; refills and PLRU touches only follow a lookup.
    always_comb begin
        superWe    = 1'b0;
        superWIdx  = addr_q[19:10];
        superWData = '{asid: bus.write_asid, ppn: bus.write_ppn[16:10], flags: bus.write_flags};
        pageWe     = 1'b0;
        pageWMask  = waySel;
        pageWIdx   = addr_q[8:0];
        pageWData  = '{tag: bus.write_tag, asid: bus.write_asid, ppn: bus.write_ppn,
                       flags: bus.write_flags, pad: 3'b000};
        lruWe      = lookupPulse_q & (|wayHit);
        lruWIdx    = addr_q[8:0];
        lruWData   = lru_d;
        if (state_q == FLUSH) begin
            superWe    = 1'b1;
            superWIdx  = flushIdx_q;
            superWData = '0;
            pageWe     = ~flushIdx_q[9];
            pageWMask  = '1;
            pageWIdx   = flushIdx_q[8:0];
            pageWData  = '0;
            lruWe      = ~flushIdx_q[9];
            lruWIdx    = flushIdx_q[8:0];
            lruWData   = '0;
        end else if (refillAccept) begin
            superWe = bus.write_super;
            pageWe  = ~bus.write_super;
        end
    end

    // Storage arrays read-first: a same-cycle refill is not visible to the lookup.
    always_ff @(posedge clk) begin
        if (superWe) begin
            superMem[superWIdx] <= superWData;
        end
        if (pageWe) begin
            for (int w = 0; w < WAYS; w++) begin
                if (pageWMask[w]) begin
                    pageMem[pageWIdx][w] <= pageWData;
                end
            end
        end
        if (lruWe) begin
            lruMem[lruWIdx] <= lruWData;
        end
        if (lookupAccept) begin
            superRd_q <= superMem[bus.read_addr[19:10]];
            setRd_q   <= pageMem[bus.read_addr[8:0]];
            lruRd_q   <= lruMem[bus.read_addr[8:0]];
        end
    end

`ifdef TLB_TRACE_EN
    always @(negedge clk) begin
        if (refillAccept && state_q == IDLE) begin
            if (bus.write_super) begin
                $display("%0t %s refill super idx=%03h asid=%03h ppn=%02h flags=%02h",
                         $time, PARENT, addr_q[19:10], bus.write_asid,
                         bus.write_ppn[16:10], bus.write_flags);
            end else begin
                $display("%0t %s refill page set=%03h ways=%b tag=%03h asid=%03h ppn=%05h flags=%02h",
                         $time, PARENT, addr_q[8:0], waySel, bus.write_tag,
                         bus.write_asid, bus.write_ppn, bus.write_flags);
            end
        end
    end
`endif

endmodule

// File: tb/tb_unique0_tlb.sv
// Self-checking bench for unique0_tlb: expected lookup results are queued as each
// lookup is driven and popped when the result appears one cycle later.
module tb_unique0_tlb;

    typedef struct packed {
        logic        hit;
        logic        sup;
        logic [16:0] ppn;
        logic [7:0]  flags;
    } resT;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    resT  expQ[$];

    unique0_tlb_if bus ();

    unique0_tlb #(.PARENT("tb")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic resT mkRes(input logic h, input logic s, input logic [16:0] p,
                                  input logic [7:0] f);
        resT r;
        r.hit   = h;
        r.sup   = s;
        r.ppn   = p;
        r.flags = f;
        return r;
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One lookup cycle, result sampled after the edge, then one idle cycle so the
    // PLRU touch lands before anything else is issued.
    task automatic doLookup(input logic [8:0] asid, input logic [19:0] addr, output resT obs);
        bus.read_asid = asid;
        bus.read_addr = addr;
        bus.read_req  = 1'b1;
        @(posedge clk);
        #1;
        bus.read_req = 1'b0;
        obs = mkRes(bus.read_hit, bus.read_super, bus.read_ppn, bus.read_flags);
        idleCycles(1);
    endtask

    task automatic doRefill(input logic sup, input logic [10:0] tag, input logic [8:0] asid,
                            input logic [16:0] ppn, input logic [7:0] flags);
        bus.write_super = sup;
        bus.write_tag   = tag;
        bus.write_asid  = asid;
        bus.write_ppn   = ppn;
        bus.write_flags = flags;
        bus.write_req   = 1'b1;
        @(posedge clk);
        #1;
        bus.write_req = 1'b0;
    endtask

    task automatic test_reset;
        int  cnt;
        resT obs;
        resT exp;
        reset = 1'b1;
        idleCycles(2);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL busy_after_reset: got %b expected 1", bus.busy);
        end
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            idleCycles(1);
            cnt++;
        end
        checks++;
        if (cnt !== 1024) begin
            fails++;
            $display("[TB] FAIL flush_length: got %0d cycles expected 1024", cnt);
        end
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(9'd0, 20'h12345, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL lookup_after_flush: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_page_refill;
        resT obs;
        resT exp;
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(9'd3, 20'h00401, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL page_miss: got %h expected %h", obs, exp);
        end
        doRefill(1'b0, 11'h002, 9'd3, 17'h1ABCD, 8'h01);
        expQ.push_back(mkRes(1'b1, 1'b0, 17'h1ABCD, 8'h01));
        doLookup(9'd3, 20'h00401, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL page_hit: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_asid;
        resT obs;
        resT exp;
        // Set 1 PLRU now points at way2, which is still empty.
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(9'd4, 20'h00401, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL asid_miss: got %h expected %h", obs, exp);
        end
        doRefill(1'b0, 11'h002, 9'd4, 17'h1ABCD, 8'h21);
        expQ.push_back(mkRes(1'b1, 1'b0, 17'h1ABCD, 8'h21));
        doLookup(9'd4, 20'h00401, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL global_hit: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_superpage;
        resT  obs;
        resT  exp;
        logic [8:0]  asids [4];
        logic [19:0] addrs [4];
        asids = '{9'd0, 9'd0, 9'd7, 9'd0};
        addrs = '{20'hFFC00, 20'hFFC00, 20'hFFC00, 20'hFFDFF};
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(asids[0], addrs[0], obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL super_miss: got %h expected %h", obs, exp);
        end
        doRefill(1'b1, 11'h7FF, 9'd0, 17'h157FF, 8'h01);
        expQ.push_back(mkRes(1'b1, 1'b1, 17'h15400, 8'h01));
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        expQ.push_back(mkRes(1'b1, 1'b1, 17'h15400, 8'h01));
        for (int i = 1; i < 4; i++) begin
            doLookup(asids[i], addrs[i], obs);
            exp = expQ.pop_front();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL super_lookup_%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_plru;
        resT         obs;
        resT         exp;
        logic [10:0] tag;
        logic [10:0] seqTag [4];
        logic [16:0] seqPpn [4];
        logic        seqHit [4];
        // Victim order from an all-zero tree with a hit after each fill: w0, w2, w1, w3.
        for (int i = 0; i < 4; i++) begin
            tag = 11'h010 + 11'(i);
            expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
            doLookup(9'd1, {tag, 9'd5}, obs);
            exp = expQ.pop_front();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL plru_fill_miss_%0d: got %h expected %h", i, obs, exp);
            end
            doRefill(1'b0, tag, 9'd1, 17'h00100 + 17'(i), 8'h01);
            expQ.push_back(mkRes(1'b1, 1'b0, 17'h00100 + 17'(i), 8'h01));
            doLookup(9'd1, {tag, 9'd5}, obs);
            exp = expQ.pop_front();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL plru_fill_hit_%0d: got %h expected %h", i, obs, exp);
            end
        end
        // Touch way0 -> victim way2 (entry 1); touch way2 -> victim way1 (entry 2).
        seqTag = '{11'h010, 11'h01F, 11'h011, 11'h01F};
        seqPpn = '{17'h00100, 17'h00101, 17'h00101, 17'h00102};
        seqHit = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(mkRes(seqHit[i], 1'b0, seqPpn[i], 8'h01));
            doLookup(9'd1, {seqTag[i], 9'd5}, obs);
            exp = expQ.pop_front();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL plru_victim_%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        resT obs;
        resT exp;
        // Refill of way1 (from the previous miss) and a lookup of the same VA in one cycle.
        bus.write_super = 1'b0;
        bus.write_tag   = 11'h01F;
        bus.write_asid  = 9'd1;
        bus.write_ppn   = 17'h1EEEE;
        bus.write_flags = 8'h01;
        bus.write_req   = 1'b1;
        bus.read_asid   = 9'd1;
        bus.read_addr   = {11'h01F, 9'd5};
        bus.read_req    = 1'b1;
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h00102, 8'h01));
        @(posedge clk);
        #1;
        bus.read_req  = 1'b0;
        bus.write_req = 1'b0;
        obs = mkRes(bus.read_hit, bus.read_super, bus.read_ppn, bus.read_flags);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL read_first: got %h expected %h", obs, exp);
        end
        idleCycles(1);
        expQ.push_back(mkRes(1'b1, 1'b0, 17'h1EEEE, 8'h01));
        doLookup(9'd1, {11'h01F, 9'd5}, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL write_landed: got %h expected %h", obs, exp);
        end
        // Entry 2 was overwritten; touching way1 makes way3 (entry 3) the victim.
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h00103, 8'h01));
        doLookup(9'd1, {11'h012, 9'd5}, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL overwritten_miss: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_midflush_reset;
        int  cnt;
        resT obs;
        resT exp;
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        idleCycles(100);
        bus.read_asid = 9'd1;
        bus.read_addr = {11'h01F, 9'd5};
        bus.read_req  = 1'b1;
        idleCycles(1);
        bus.read_req = 1'b0;
        checks++;
        if (bus.read_hit !== 1'b0) begin
            fails++;
            $display("[TB] FAIL hit_during_flush: got %b expected 0", bus.read_hit);
        end
        idleCycles(199);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            idleCycles(1);
            cnt++;
        end
        checks++;
        if (cnt !== 1024) begin
            fails++;
            $display("[TB] FAIL restarted_flush_length: got %0d cycles expected 1024", cnt);
        end
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(9'd3, 20'h00401, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL page_flushed: got %h expected %h", obs, exp);
        end
        expQ.push_back(mkRes(1'b0, 1'b0, 17'h0, 8'h00));
        doLookup(9'd0, 20'hFFC00, obs);
        exp = expQ.pop_front();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL super_flushed: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        fails           = 0;
        reset           = 1'b0;
        bus.read_req    = 1'b0;
        bus.read_asid   = '0;
        bus.read_addr   = '0;
        bus.write_req   = 1'b0;
        bus.write_super = 1'b0;
        bus.write_tag   = '0;
        bus.write_asid  = '0;
        bus.write_ppn   = '0;
        bus.write_flags = '0;
        #1;
        test_reset;
        test_page_refill;
        test_asid;
        test_superpage;
        test_plru;
        test_back_to_back;
        test_midflush_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/unique0_tlb.md
Name: unique0_tlb

Overview:
- Unified translation lookaside buffer for Sv32-style translation.
- Holds a direct-mapped 1024-entry superpage (4 MiB) store and a 512-set, 4-way 4 KiB page store with 3-bit tree pseudo-LRU per set.
- Sits between the address-generation stage and the page-table walker.
- The walker refills the entry selected by the preceding lookup.

Parameters:
- PARENT, "", instance label string printed in trace messages.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- busy  out  1  high while the post-reset flush runs; lookups are ignored.
- read_req  in  1  start lookup.
- read_asid  in  9  address-space ID of the lookup.
- read_addr  in  20  virtual page number, VA[31:12].
- read_hit  out  1  superpage hit OR any 4 KiB way hit.
- read_super  out  1  superpage hit.
- read_ppn  out  17  physical page number, PA[28:12].
- read_flags  out  8  PTE flags; bit0 = V, bit5 = G.
- write_req  in  1  refill strobe.
- write_super  in  1  refill targets the superpage store.
- write_tag  in  11  VA[31:21] tag for a 4 KiB refill.
- write_asid  in  9  refill ASID.
- write_ppn  in  17  refill PPN; for a superpage only [28:22] is stored.
- write_flags  in  8  refill flags.

Behaviour:
- Lookup latency is 1 cycle.
  - On cycle N with read_req=1: capture asid/addr into *_r registers, read super_mem[addr[31:22]], set data[addr[20:12]] and lru[addr[20:12]].
  - In cycle N+1 the outputs are combinational from the stored data. They hold until the next read_req.
- Superpage hit: V & (G | asid==asid_r).
- Way i hit: V_i & (G_i | asid_i==asid_r) & tag_i==addr_r[31:21].
- Output selection:
  - Super hit has priority: read_ppn = {super_ppn[28:22], 10'b0}, read_flags = super flags.
  - Else a hit way drives ppn/flags.
  - On a miss, the pseudo-LRU victim way drives ppn/flags and is the refill target.
- Refill uses the index and way of the most recent lookup. write_req is legal only in cycles after a lookup, before the next read_req.
  - write_super=1: super_mem[addr_r[31:22]] <= {asid, ppn[28:22], flags}. write_tag is ignored.
  - write_super=0: write {tag, asid, ppn, flags} into every way selected (hit way, else victim) of set addr_r[20:12].
- Pseudo-LRU bits [2:0] are decoded as follows.
  - 0?0 -> way0; 0?1 -> way1; 10? -> way2; 11? -> way3.
- Pseudo-LRU update happens only in the cycle after a lookup with a 4 KiB way hit. A super-only hit or a miss leaves LRU unchanged.
  - Hit way0: b2=1, b0=1.
  - Hit way1: b2=1, b0=0.
  - Hit way2: b2=0, b1=1.
  - Hit way3: b2=0, b1=0.
  - Untouched bits are kept.
- Simultaneous read_req and write_req: the write goes to the old *_r index. The read returns the pre-write contents (read-first).
- Reset handling:
  - reset clears read_req_r and asserts busy.
  - After reset deasserts, a flush FSM (IDLE/FLUSH) zeroes index 0..1023 of super_mem and index 0..511 of data/LRU, one index per cycle, then drops busy. This takes 1024 cycles.
  - During the flush read_hit=0 and read_req/write_req are ignored.
  - Reset asserted mid-flush restarts the flush at index 0.
- Flush completes with every entry invalid (V=0).

Optional Feature:
- Macro TLB_TRACE_EN.
- When defined, on the falling clock edge each refill prints:
  - Superpage: time, PARENT, index, asid, ppn[28:22], flags.
  - 4 KiB: time, PARENT, set, way mask, tag, asid, ppn, flags.
- When undefined, no trace logic is compiled. Functional behaviour is identical either way.

Decomposition:
- Package tlb_pkg:
  - Packed 4 KiB entry struct (tag 11, asid 9, ppn 17, flags 8, pad 3 = 48 bits) and superpage entry struct (24 bits).
  - Constants FLAG_V=0, FLAG_G=5, SETS=512, WAYS=4, SUPER_ENTRIES=1024.
- Sub-module plru_tree:
  - Inputs: current 3 LRU bits and 4-bit hit vector.
  - Outputs: next LRU bits and one-hot victim.

Test Plan:
- Reset then 1024 idle cycles -> busy falls at cycle 1024; a lookup on VA 0x12345 gives read_hit=0.
- Lookup VA[31:12]=0x00401 asid 3 (miss, victim way0) -> write_super=0, tag 0x002, ppn 0x1ABCD, flags 0x01 -> relookup gives hit, ppn 0x1ABCD, flags 0x01.
- Same entry, lookup with asid 4 -> miss. Rewrite with flags 0x21 (G) -> asid 4 hits.
- Super refill at index 0x3FF, ppn[28:22]=0x55, flags 0x01, asid 0 -> lookup 0xFFC00 gives read_super=1, ppn 0x15400.
- Fill set 5 ways 0..3 in victim order, hit way0 -> next victim is way2. Then hit way2 -> next victim is way1.
- Assert reset for 1 cycle at flush index 300 -> flush restarts at 0; busy lasts 1024 more cycles.
